uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//   Receive buffer directly downstream of the UART receiver. Captures every received byte
//   on the receiver's one-cycle done strobe and stores it in a circular FIFO.
//   Presents bytes to the host side through a valid/ready show-ahead interface.
//   Flags overflow so the host can detect bytes lost while the buffer was full.
// PARAMETERS
//   DATA_W    8   byte width; matches receiver data_out
//   DEPTH     16  storage entries; must be a power of 2, >= 2
//   ADDR_W    4   log2(DEPTH)
//   AF_LEVEL  12  almost_full asserts when count >= AF_LEVEL
// PORTS
//   clk          in   1         system clock; same clock as the receiver
//   rst          in   1         reset: one clock, synchronous, active-high
//   wr_stb       in   1         one-cycle write strobe; driven by receiver rx_done
//   wr_data      in   DATA_W    byte to store; driven by receiver data_out; sampled when wr_stb=1
//   rd_valid     out  1         rd_data holds the oldest stored byte
//   rd_ready     in   1         consumer accepts; pop occurs when rd_valid & rd_ready
//   rd_data      out  DATA_W    oldest byte (show-ahead)
//   count        out  ADDR_W+1  bytes currently stored, 0..DEPTH
//   empty        out  1         count==0
//   full         out  1         count==DEPTH
//   almost_full  out  1         count>=AF_LEVEL
//   overflow     out  1         sticky: a write was dropped
//   clr_ovf      in   1         one-cycle pulse; clears overflow
// BEHAVIOUR
//   - Reset (sync, rst=1 at posedge):
//     - wr_ptr = rd_ptr = 0; count = 0; rd_valid = 0; rd_data = 0.
//     - overflow = 0; empty = 1; full = 0; almost_full = 0.
//     - Reset during a transfer discards all stored bytes. A wr_stb in the same cycle as rst is ignored.
//   - Write: wr_stb=1 and (!full or pop in the same cycle).
//     - Store wr_data at wr_ptr; wr_ptr increments.
//   - Pop: rd_valid & rd_ready. rd_ptr increments.
//   - Pointers wrap naturally modulo DEPTH (ADDR_W bits).
//   - count is ADDR_W+1 bits so that full and empty are distinguishable.
//   - count update per cycle: +1 on write only; -1 on pop only; unchanged on both or neither.
//   - Latency: a byte written into an empty FIFO at edge N gives rd_valid=1 and valid rd_data after edge N+1.
//   - rd_data and rd_valid stay stable while rd_valid=1 and rd_ready=0.
//   - Flags empty, full, almost_full and count are registered and coherent with each other every cycle.
//   - Full with wr_stb and no pop:
//     - The byte is dropped and overflow sets.
//     - Stored contents, pointers and count are unchanged.
//   - Full with wr_stb and pop in the same cycle: the write is accepted; count stays DEPTH.
//   - Empty with rd_ready=1 and no data: no pop occurs; no pointer moves.
//   - Empty with wr_stb and rd_ready in the same cycle: the write is accepted; no pop (rd_valid was 0).
//   - clr_ovf and a new dropped write in the same cycle: set wins; overflow stays 1.
//   - wr_stb is a single-cycle strobe. Back-to-back strobes on consecutive cycles are each stored.
//   - No state machine beyond the pointer/count logic.
//   - The output stage is one register with a valid bit, refilled from storage on pop or when empty.
// STRUCTURE
//   - uart_pkg (shared): DATA_W, default DEPTH/ADDR_W, AF_LEVEL constants. Also used by tx/rx.
//   - Sub-module uart_fifo_mem: DEPTH x DATA_W simple dual-port RAM.
//     - Synchronous write; synchronous read with read enable.
//     - Pointer, count, flag and output-register logic stay in uart_rx_fifo.
// TESTING
//   - Reset: assert rst with FIFO half full -> next cycle count=0, empty=1, rd_valid=0, overflow=0.
//   - Single byte: wr_stb with 0xA5 -> rd_valid=1 one cycle later, rd_data=0xA5.
//     - Pulse rd_ready -> empty=1, count=0.
//   - Fill/wrap: write 0x00..0x0F (16) -> full=1, almost_full=1 from 12th write.
//     - Read 8, write 0x10..0x17, drain -> exact order 0x08..0x17.
//   - Overflow: full, wr_stb 0xEE with rd_ready=0 -> overflow=1, 0xEE never read.
//     - clr_ovf -> overflow=0.
//   - Simultaneous at full: wr_stb 0x55 with pop -> count stays 16; 0x55 emerges last.
//   - Back-pressure: rd_ready=0 for 20 cycles with rd_valid=1 -> rd_data constant.
//     - clr_ovf coincident with a drop -> overflow stays 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: byte width and default receive-buffer geometry.
// Imported by the tx, rx and FIFO blocks.
package uart_pkg;

   localparam int UART_DATA_W   = 8;
   localparam int FIFO_DEPTH    = 16;
   localparam int FIFO_ADDR_W   = 4;
   localparam int FIFO_AF_LEVEL = 12;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W simple dual-port RAM: synchronous write, registered read with enable.
// The read register doubles as the FIFO's show-ahead output stage, so it is reset.
module uart_fifo_mem #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: stores bytes on wr_stb, show-ahead valid/ready read side, sticky overflow.
// First byte into an empty FIFO is visible one cycle after its write; output holds while !rd_ready.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_W   = UART_DATA_W,
   parameter int DEPTH    = FIFO_DEPTH,
   parameter int ADDR_W   = FIFO_ADDR_W,
   parameter int AF_LEVEL = FIFO_AF_LEVEL
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_stb,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W:0]   count,
   output logic              empty,
   output logic              full,
   output logic              almost_full,
   output logic              overflow,
   input  logic              clr_ovf
);

   localparam int              CW      = ADDR_W + 1;
   localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0]   AF_C    = CW'(AF_LEVEL);

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [CW-1:0]     ram_cnt;
   logic              rd_valid_q, rd_valid_d;
   logic              empty_q, full_q, af_q;
   logic              ovf_q, ovf_d;
   logic              pop, wr_en, fetch;

   always_comb begin
      pop     = rd_valid_q & rd_ready;
      wr_en   = wr_stb & (~full_q | pop);
      // count includes the byte held in the output stage; ram_cnt is what is still unfetched
      ram_cnt = count_q - {{ADDR_W{1'b0}}, rd_valid_q};
      fetch   = (ram_cnt != '0) & (~rd_valid_q | pop);

      wr_ptr_d = wr_en ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
      rd_ptr_d = fetch ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;

      count_d = count_q;
      case ({wr_en, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      rd_valid_d = rd_valid_q;
      if (fetch) begin
         rd_valid_d = 1'b1;
      end else if (pop) begin
         rd_valid_d = 1'b0;
      end

      ovf_d = ovf_q;
      if (wr_stb & ~wr_en) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_valid_q <= 1'b0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         af_q       <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_valid_q <= rd_valid_d;
         empty_q    <= (count_d == '0);
         full_q     <= (count_d == DEPTH_C);
         af_q       <= (count_d >= AF_C);
         ovf_q      <= ovf_d;
      end
   end

   uart_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .we_i    (wr_en & ~rst),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_data),
      .re_i    (fetch & ~rst),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_data)
   );

   assign rd_valid    = rd_valid_q;
   assign count       = count_q;
   assign empty       = empty_q;
   assign full        = full_q;
   assign almost_full = af_q;
   assign overflow    = ovf_q;

endmodule
